// File: rtl/ifm_pingpong_mem_array_pkg.sv
// Shared types and helpers for the ping/pong IFM store.
//   bank_t      : index of one of the two banks
//   addr_width  : $clog2 clamped to at least 1 bit
//   calc_slots  : IFMs held per lane, ceil(NUMBER_OF_IFM / NUMBER_OF_UNITS)
//   calc_sel_w  : width of the ifm_sel slot index
//   lane_lo     : low bit of lane u inside a packed multi-lane bus
package ifm_pingpong_mem_array_pkg;

   typedef logic bank_t;

   function automatic int unsigned addr_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned calc_slots(input int unsigned n_ifm,
                                              input int unsigned units);
      return (n_ifm + units - 1) / units;
   endfunction

   function automatic int unsigned calc_sel_w(input int unsigned slots);
      return addr_width(slots);
   endfunction

   function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned dw);
      return lane * dw;
   endfunction

endpackage

// File: rtl/ifm_pingpong_mem_array_bank_ram.sv
// Simple dual-port RAM for one lane of one bank, synchronous read.
//   clk              : clock
//   a_en/a_we        : port A enable / write select (write when a_we, else read)
//   a_addr/a_wdata   : port A address / write data
//   a_rdata          : port A registered read data, holds when not reading
//   b_en/b_addr      : port B read enable / address
//   b_rdata          : port B registered read data, holds when not reading
// A read on B to the word A is writing in the same cycle returns the old word.
module ifm_bank_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 196,
   parameter int unsigned ADDR_W     = 8
) (
   input  logic                  clk,
   input  logic                  a_en,
   input  logic                  a_we,
   input  logic [ADDR_W-1:0]     a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_en,
   input  logic [ADDR_W-1:0]     b_addr,
   output logic [DATA_WIDTH-1:0] b_rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (a_en) begin
         if (a_we) begin
            mem[a_addr] <= a_wdata;
         end else begin
            a_rdata <= mem[a_addr];
         end
      end
      if (b_en) begin
         b_rdata <= mem[b_addr];
      end
   end

endmodule

// File: rtl/ifm_pingpong_mem_array.sv
// Double-buffered IFM storage between two CNN layers. The producer fills bank wr_bank
// (write + readback), the consumer drains bank rd_bank (two read ports); ownership moves
// with the prev_done / next_done pulses.
//   clk, reset_n                      : clock, async active-low reset
//   ifm_sel                           : IFM slot within each lane, shared by all ports
//   prev_ready / prev_done            : fill bank free / fill bank complete pulse
//   ifm_*_previous, data_in_from_previous, data_out_for_previous : fill-bank ports
//   next_valid / next_done            : drain bank full / consumer finished pulse
//   ifm_*_A_next, ifm_*_B_next, data_out_A/B_for_next : drain-bank read ports
//   occupancy                         : number of full banks
//   overflow_err                      : sticky, write or done issued while !prev_ready
module ifm_pingpong_mem_array
   import ifm_pingpong_mem_array_pkg::*;
#(
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned IFM_SIZE         = 14,
   parameter int unsigned NUMBER_OF_IFM    = 2,
   parameter int unsigned NUMBER_OF_UNITS  = 1,
   parameter int unsigned ADDRESS_SIZE_IFM = addr_width(IFM_SIZE * IFM_SIZE),
   parameter int unsigned SLOTS            = calc_slots(NUMBER_OF_IFM, NUMBER_OF_UNITS),
   parameter int unsigned SEL_W            = calc_sel_w(SLOTS)
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [SEL_W-1:0]                      ifm_sel,
   output logic                                  prev_ready,
   input  logic                                  prev_done,
   input  logic                                  ifm_enable_write_previous,
   input  logic [ADDRESS_SIZE_IFM-1:0]           ifm_address_write_previous,
   input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] data_in_from_previous,
   input  logic                                  ifm_enable_read_previous,
   input  logic [ADDRESS_SIZE_IFM-1:0]           ifm_address_read_previous,
   output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] data_out_for_previous,
   output logic                                  next_valid,
   input  logic                                  next_done,
   input  logic                                  ifm_enable_read_A_next,
   input  logic                                  ifm_enable_read_B_next,
   input  logic [ADDRESS_SIZE_IFM-1:0]           ifm_address_read_A_next,
   input  logic [ADDRESS_SIZE_IFM-1:0]           ifm_address_read_B_next,
   output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] data_out_A_for_next,
   output logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] data_out_B_for_next,
   output logic [1:0]                            occupancy,
   output logic                                  overflow_err
);

   localparam int unsigned AREA   = IFM_SIZE * IFM_SIZE;
   localparam int unsigned DEPTH  = SLOTS * AREA;
   localparam int unsigned RAM_AW = addr_width(DEPTH);
   localparam int unsigned LW     = NUMBER_OF_UNITS * DATA_WIDTH;
   // Read channel indices: fill-bank readback, drain port A, drain port B.
   localparam int unsigned RD_PREV = 0;
   localparam int unsigned RD_A    = 1;
   localparam int unsigned RD_B    = 2;

   function automatic logic [RAM_AW-1:0] compose(input logic [SEL_W-1:0]            sel,
                                                 input logic [ADDRESS_SIZE_IFM-1:0] addr);
      return RAM_AW'(32'(sel) * AREA + 32'(addr));
   endfunction

   // ---------------- bank ownership handshake ----------------
   bank_t      wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
   logic [1:0] full_q, full_d;
   logic       overflow_q, overflow_d;

   assign prev_ready   = ~full_q[wr_bank_q];
   assign next_valid   = full_q[rd_bank_q];
   assign occupancy    = 2'(full_q[0]) + 2'(full_q[1]);
   assign overflow_err = overflow_q;

   always_comb begin
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      full_d     = full_q;
      overflow_d = overflow_q;
      if (prev_done) begin
         if (prev_ready) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            overflow_d = 1'b1;
         end
      end
      if (ifm_enable_write_previous && !prev_ready) begin
         overflow_d = 1'b1;
      end
      // Simultaneous done pulses always address different banks, so both apply.
      if (next_done && next_valid) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = ~rd_bank_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         full_q     <= 2'b00;
         overflow_q <= 1'b0;
      end else begin
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         full_q     <= full_d;
         overflow_q <= overflow_d;
      end
   end

   // ---------------- RAM port steering ----------------
   logic              sel_ok;
   logic              we_ok;
   logic              a_en   [2];
   logic              a_we   [2];
   logic [RAM_AW-1:0] a_addr [2];
   logic              b_en   [2];
   logic [RAM_AW-1:0] b_addr [2];
   logic              prev_hit [2];
   logic              next_b_hit [2];

   assign sel_ok = 32'(ifm_sel) < SLOTS;
   assign we_ok  = ifm_enable_write_previous & prev_ready & sel_ok;

   // wr_bank == rd_bank only when both banks are empty or both full. Port A: an accepted
   // write wins (it implies the bank is not full). Port B: the consumer wins when the bank
   // is full, the producer readback wins when it is empty.
   always_comb begin
      for (int b = 0; b < 2; b++) begin
         a_en[b]       = 1'b0;
         a_we[b]       = 1'b0;
         a_addr[b]     = compose(ifm_sel, ifm_address_read_A_next);
         b_en[b]       = 1'b0;
         b_addr[b]     = compose(ifm_sel, ifm_address_read_previous);
         prev_hit[b]   = ifm_enable_read_previous & sel_ok & (wr_bank_q == bank_t'(b));
         next_b_hit[b] = ifm_enable_read_B_next & sel_ok & (rd_bank_q == bank_t'(b));
         if (we_ok && (wr_bank_q == bank_t'(b))) begin
            a_en[b]   = 1'b1;
            a_we[b]   = 1'b1;
            a_addr[b] = compose(ifm_sel, ifm_address_write_previous);
         end else if (ifm_enable_read_A_next && sel_ok && (rd_bank_q == bank_t'(b))) begin
            a_en[b] = 1'b1;
         end
         if (next_b_hit[b] && (full_q[b] || !prev_hit[b])) begin
            b_en[b]   = 1'b1;
            b_addr[b] = compose(ifm_sel, ifm_address_read_B_next);
         end else if (prev_hit[b]) begin
            b_en[b] = 1'b1;
         end
      end
   end

   logic [DATA_WIDTH-1:0] ram_qa [2][NUMBER_OF_UNITS];
   logic [DATA_WIDTH-1:0] ram_qb [2][NUMBER_OF_UNITS];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      for (genvar u = 0; u < NUMBER_OF_UNITS; u++) begin : g_lane
         ifm_bank_ram #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_W     (RAM_AW)
         ) u_ram (
            .clk     (clk),
            .a_en    (a_en[b]),
            .a_we    (a_we[b]),
            .a_addr  (a_addr[b]),
            .a_wdata (data_in_from_previous[lane_lo(u, DATA_WIDTH) +: DATA_WIDTH]),
            .a_rdata (ram_qa[b][u]),
            .b_en    (b_en[b]),
            .b_addr  (b_addr[b]),
            .b_rdata (ram_qb[b][u])
         );
      end
   end

   // ---------------- read output channels ----------------
   // The RAM output registers can be disturbed by the other role after a bank swap, so
   // each channel keeps its own copy and shows fresh RAM data only in the cycle after
   // its enable.
   logic          rd_en   [3];
   bank_t         rd_src  [3];
   logic          pend_q  [3];
   bank_t         bank_q  [3];
   logic          zero_q  [3];
   logic [LW-1:0] hold_q  [3];
   logic [LW-1:0] fresh   [3];
   logic [LW-1:0] rd_out  [3];

   always_comb begin
      rd_en[RD_PREV]  = ifm_enable_read_previous;
      rd_en[RD_A]     = ifm_enable_read_A_next;
      rd_en[RD_B]     = ifm_enable_read_B_next;
      rd_src[RD_PREV] = wr_bank_q;
      rd_src[RD_A]    = rd_bank_q;
      rd_src[RD_B]    = rd_bank_q;
   end

   always_comb begin
      for (int p = 0; p < 3; p++) begin
         fresh[p] = '0;
      end
      for (int u = 0; u < NUMBER_OF_UNITS; u++) begin
         fresh[RD_PREV][u*DATA_WIDTH +: DATA_WIDTH] = ram_qb[bank_q[RD_PREV]][u];
         fresh[RD_A][u*DATA_WIDTH +: DATA_WIDTH]    = ram_qa[bank_q[RD_A]][u];
         fresh[RD_B][u*DATA_WIDTH +: DATA_WIDTH]    = ram_qb[bank_q[RD_B]][u];
      end
      for (int p = 0; p < 3; p++) begin
         if (!pend_q[p]) begin
            rd_out[p] = hold_q[p];
         end else if (zero_q[p]) begin
            rd_out[p] = '0;
         end else begin
            rd_out[p] = fresh[p];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < 3; p++) begin
            pend_q[p] <= 1'b0;
            bank_q[p] <= 1'b0;
            zero_q[p] <= 1'b0;
            hold_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 3; p++) begin
            pend_q[p] <= rd_en[p];
            hold_q[p] <= rd_out[p];
            if (rd_en[p]) begin
               bank_q[p] <= rd_src[p];
               zero_q[p] <= ~sel_ok;
            end
         end
      end
   end

   assign data_out_for_previous = rd_out[RD_PREV];
   assign data_out_A_for_next   = rd_out[RD_A];
   assign data_out_B_for_next   = rd_out[RD_B];

endmodule

// File: tb/tb_ifm_pingpong_mem_array.sv
module tb_ifm_pingpong_mem_array;

   localparam int DW    = 32;
   localparam int SZ    = 4;
   localparam int NIFM  = 4;
   localparam int UNITS = 2;
   localparam int AREA  = SZ * SZ;
   localparam int NSLOT = 2;
   localparam int AW    = 4;
   localparam int SW    = 1;
   localparam int LW    = UNITS * DW;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [SW-1:0] ifm_sel;
   logic          prev_ready, prev_done;
   logic          ifm_enable_write_previous, ifm_enable_read_previous;
   logic [AW-1:0] ifm_address_write_previous, ifm_address_read_previous;
   logic [LW-1:0] data_in_from_previous, data_out_for_previous;
   logic          next_valid, next_done;
   logic          ifm_enable_read_A_next, ifm_enable_read_B_next;
   logic [AW-1:0] ifm_address_read_A_next, ifm_address_read_B_next;
   logic [LW-1:0] data_out_A_for_next, data_out_B_for_next;
   logic [1:0]    occupancy;
   logic          overflow_err;

   always #5 clk = ~clk;

   ifm_pingpong_mem_array #(
      .DATA_WIDTH      (DW),
      .IFM_SIZE        (SZ),
      .NUMBER_OF_IFM   (NIFM),
      .NUMBER_OF_UNITS (UNITS)
   ) dut (
      .clk                        (clk),
      .reset_n                    (reset_n),
      .ifm_sel                    (ifm_sel),
      .prev_ready                 (prev_ready),
      .prev_done                  (prev_done),
      .ifm_enable_write_previous  (ifm_enable_write_previous),
      .ifm_address_write_previous (ifm_address_write_previous),
      .data_in_from_previous      (data_in_from_previous),
      .ifm_enable_read_previous   (ifm_enable_read_previous),
      .ifm_address_read_previous  (ifm_address_read_previous),
      .data_out_for_previous      (data_out_for_previous),
      .next_valid                 (next_valid),
      .next_done                  (next_done),
      .ifm_enable_read_A_next     (ifm_enable_read_A_next),
      .ifm_enable_read_B_next     (ifm_enable_read_B_next),
      .ifm_address_read_A_next    (ifm_address_read_A_next),
      .ifm_address_read_B_next    (ifm_address_read_B_next),
      .data_out_A_for_next        (data_out_A_for_next),
      .data_out_B_for_next        (data_out_B_for_next),
      .occupancy                  (occupancy),
      .overflow_err               (overflow_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Bank ownership from fill/drain counts: fill bank = fills mod 2, drain bank =
   // drains mod 2, number of full banks = fills - drains.
   int            fills = 0;
   int            drains = 0;
   logic          ovf_m = 1'b0;
   logic [DW-1:0] mm [2][UNITS][NSLOT*AREA];
   logic [LW-1:0] q_prev[$];
   logic [LW-1:0] q_a[$];
   logic [LW-1:0] q_b[$];
   int            occ_m, wr_m, rd_m;

   function automatic logic [LW-1:0] model_read(input int bank, input int sel, input int addr);
      logic [LW-1:0] v;
      for (int u = 0; u < UNITS; u++) v[u*DW +: DW] = mm[bank][u][sel*AREA + addr];
      return v;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fills  = 0;
         drains = 0;
         ovf_m  = 1'b0;
      end else begin
         occ_m = fills - drains;
         wr_m  = fills % 2;
         rd_m  = drains % 2;
         // Reads see memory before this edge's write.
         if (ifm_enable_read_previous)
            q_prev.push_back(model_read(wr_m, int'(ifm_sel), int'(ifm_address_read_previous)));
         if (ifm_enable_read_A_next)
            q_a.push_back(model_read(rd_m, int'(ifm_sel), int'(ifm_address_read_A_next)));
         if (ifm_enable_read_B_next)
            q_b.push_back(model_read(rd_m, int'(ifm_sel), int'(ifm_address_read_B_next)));
         if (ifm_enable_write_previous) begin
            if (occ_m < 2) begin
               for (int u = 0; u < UNITS; u++)
                  mm[wr_m][u][int'(ifm_sel)*AREA + int'(ifm_address_write_previous)] =
                     data_in_from_previous[u*DW +: DW];
            end else begin
               ovf_m = 1'b1;
            end
         end
         if (prev_done) begin
            if (occ_m < 2) fills++;
            else ovf_m = 1'b1;
         end
         if (next_done && occ_m > 0) drains++;
      end
   end

   // ---------------- monitor ----------------
   logic [LW-1:0] last_prev = '0;
   logic [LW-1:0] last_a = '0;
   logic [LW-1:0] last_b = '0;
   int            occ_mon;

   always @(negedge clk) begin
      if (!reset_n) begin
         q_prev.delete();
         q_a.delete();
         q_b.delete();
         last_prev = '0;
         last_a    = '0;
         last_b    = '0;
      end else begin
         if (q_prev.size() > 0) last_prev = q_prev.pop_front();
         if (q_a.size() > 0) last_a = q_a.pop_front();
         if (q_b.size() > 0) last_b = q_b.pop_front();
      end
      chk("prev_data", data_out_for_previous, last_prev);
      chk("next_a_data", data_out_A_for_next, last_a);
      chk("next_b_data", data_out_B_for_next, last_b);
      occ_mon = fills - drains;
      chk("prev_ready", LW'(prev_ready), LW'(occ_mon < 2));
      chk("next_valid", LW'(next_valid), LW'(occ_mon > 0));
      chk("occupancy", LW'(occupancy), LW'(occ_mon));
      chk("overflow_err", LW'(overflow_err), LW'(ovf_m));
   end

   // ---------------- stimulus ----------------
   task automatic idle();
      ifm_enable_write_previous = 1'b0;
      ifm_enable_read_previous  = 1'b0;
      ifm_enable_read_A_next    = 1'b0;
      ifm_enable_read_B_next    = 1'b0;
      prev_done                 = 1'b0;
      next_done                 = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [LW-1:0] snap;
   int            occ_d;

   initial begin
      idle();
      ifm_sel                    = '0;
      ifm_address_write_previous = '0;
      ifm_address_read_previous  = '0;
      ifm_address_read_A_next    = '0;
      ifm_address_read_B_next    = '0;
      data_in_from_previous      = '0;
      reset_n                    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // 1: reset state
      chk("t1_prev_ready", LW'(prev_ready), LW'(1));
      chk("t1_next_valid", LW'(next_valid), LW'(0));
      chk("t1_occupancy", LW'(occupancy), LW'(0));
      chk("t1_data_prev", data_out_for_previous, '0);
      chk("t1_data_a", data_out_A_for_next, '0);
      chk("t1_data_b", data_out_B_for_next, '0);

      // Give every RAM word a known value, then hand both banks back.
      for (int b = 0; b < 2; b++) begin
         for (int s = 0; s < NSLOT; s++) begin
            for (int a = 0; a < AREA; a++) begin
               ifm_sel                    = SW'(s);
               ifm_address_write_previous = AW'(a);
               data_in_from_previous      = {$urandom, $urandom};
               ifm_enable_write_previous  = 1'b1;
               tick();
            end
         end
         prev_done = 1'b1;
         tick();
      end
      next_done = 1'b1;
      tick();
      next_done = 1'b1;
      tick();

      // 2: write, hand over, read on port A
      ifm_sel                    = 1'b1;
      ifm_address_write_previous = 4'd5;
      data_in_from_previous      = {32'h0000005A, 32'h000000A5};
      ifm_enable_write_previous  = 1'b1;
      tick();
      prev_done = 1'b1;
      tick();
      ifm_address_read_A_next = 4'd5;
      ifm_enable_read_A_next  = 1'b1;
      tick();
      chk("t2_data_a", data_out_A_for_next, {32'h0000005A, 32'h000000A5});
      chk("t2_next_valid", LW'(next_valid), LW'(1));
      next_done = 1'b1;
      tick();

      // 3: both banks full, extra write dropped
      prev_done = 1'b1;
      tick();
      prev_done = 1'b1;
      tick();
      chk("t3_prev_ready", LW'(prev_ready), LW'(0));
      chk("t3_occupancy", LW'(occupancy), LW'(2));
      ifm_address_write_previous = 4'd7;
      data_in_from_previous      = {32'hDEADBEEF, 32'hCAFEF00D};
      ifm_enable_write_previous  = 1'b1;
      tick();
      chk("t3_overflow", LW'(overflow_err), LW'(1));
      ifm_address_read_A_next = 4'd7;
      ifm_enable_read_A_next  = 1'b1;
      ifm_address_read_B_next = 4'd5;
      ifm_enable_read_B_next  = 1'b1;
      tick();
      next_done = 1'b1;
      tick();

      // 4: simultaneous done pulses at occupancy 1
      prev_done = 1'b1;
      next_done = 1'b1;
      tick();
      chk("t4_occupancy", LW'(occupancy), LW'(1));
      ifm_address_read_A_next = 4'd5;
      ifm_enable_read_A_next  = 1'b1;
      tick();

      // 5: readback during write to the same word returns the old word
      ifm_sel                    = 1'b0;
      ifm_address_write_previous = 4'd3;
      data_in_from_previous      = {32'h11, 32'h11};
      ifm_enable_write_previous  = 1'b1;
      tick();
      ifm_address_write_previous = 4'd3;
      data_in_from_previous      = {32'h22, 32'h22};
      ifm_enable_write_previous  = 1'b1;
      ifm_address_read_previous  = 4'd3;
      ifm_enable_read_previous   = 1'b1;
      tick();
      chk("t5_old_data", data_out_for_previous, {32'h11, 32'h11});
      ifm_enable_read_previous = 1'b1;
      tick();
      chk("t5_new_data", data_out_for_previous, {32'h22, 32'h22});

      // 6: reset mid-fill, RAM keeps its contents
      ifm_sel                    = 1'b1;
      ifm_address_write_previous = 4'd9;
      data_in_from_previous      = {$urandom, $urandom};
      ifm_enable_write_previous  = 1'b1;
      ifm_address_read_A_next    = 4'd5;
      ifm_enable_read_A_next     = 1'b1;
      tick();
      snap    = model_read(0, 1, 5);
      reset_n = 1'b0;
      #1;
      chk("t6_data_prev", data_out_for_previous, '0);
      chk("t6_data_a", data_out_A_for_next, '0);
      chk("t6_prev_ready", LW'(prev_ready), LW'(1));
      chk("t6_occupancy", LW'(occupancy), LW'(0));
      chk("t6_overflow", LW'(overflow_err), LW'(0));
      @(posedge clk);
      #1;
      reset_n   = 1'b1;
      prev_done = 1'b1;
      tick();
      ifm_sel                 = 1'b1;
      ifm_address_read_A_next = 4'd5;
      ifm_enable_read_A_next  = 1'b1;
      tick();
      chk("t6_retained", data_out_A_for_next, snap);
      next_done = 1'b1;
      tick();

      // Random traffic; reads kept to ports that own their bank exclusively.
      for (int i = 0; i < 1500; i++) begin
         if (i == 700) begin
            reset_n = 1'b0;
            @(posedge clk);
            #1;
            reset_n = 1'b1;
         end
         occ_d   = fills - drains;
         ifm_sel = SW'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            ifm_enable_write_previous  = 1'b1;
            ifm_address_write_previous = AW'($urandom_range(0, AREA - 1));
            data_in_from_previous      = {$urandom, $urandom};
         end
         if (occ_d < 2 && $urandom_range(0, 2) == 0) begin
            ifm_enable_read_previous  = 1'b1;
            ifm_address_read_previous = AW'($urandom_range(0, AREA - 1));
         end
         if (occ_d > 0 && $urandom_range(0, 2) > 0) begin
            ifm_enable_read_A_next  = 1'b1;
            ifm_address_read_A_next = AW'($urandom_range(0, AREA - 1));
         end
         if (occ_d > 0 && $urandom_range(0, 2) > 0) begin
            ifm_enable_read_B_next  = 1'b1;
            ifm_address_read_B_next = AW'($urandom_range(0, AREA - 1));
         end
         prev_done = ($urandom_range(0, 11) == 0);
         next_done = ($urandom_range(0, 11) == 0);
         tick();
      end

      repeat (3) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
